branch_predictor_bht: RTL and testbench

Dynamic branch predictor for the pipelined RV32 core. It produces the taken/not-taken prediction for the conditional branch in fetch (`BrPred_f`) and carries that prediction to execute as `BrPred_x`, where the pipelined controller compares it against the resolved outcome. It trains a PC-indexed table of 2-bit saturating counters from the controller's execute-stage resolution (`Br_x`, `BrTrue`). It also keeps branch and mispredict event counters for performance analysis.

---
 rtl/branch_predictor_bht_pkg.sv | 20 ++
 rtl/branch_predictor_bht_if.sv | 26 ++
 rtl/bp_counter_table.sv | 33 +++
 rtl/branch_predictor_bht.sv | 74 +++++++
 tb/tb_branch_predictor_bht.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/branch_predictor_bht_pkg.sv
// Shared constants and counter arithmetic for the BHT branch predictor.
package bp_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam int unsigned IDX_W_DEFAULT = 6;

  // 2-bit saturating step toward the resolved direction.
  function automatic logic [1:0] sat_update(input logic [1:0] state, input logic taken);
    if (taken) begin
      return (state == ST) ? ST : state + 2'd1;
    end else begin
      return (state == SNT) ? SNT : state - 2'd1;
    end
  endfunction

endpackage

// File: rtl/branch_predictor_bht_if.sv
// Fetch/execute-side signals between the core pipeline and the branch predictor.
interface branch_predictor_bht_if #(
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned CWIDTH = 32
);
  logic [AWIDTH-1:0] pc_f;
  logic              Br_f;
  logic              Br_x;
  logic              BrTrue;
  logic              stall;
  logic              flush;
  logic              BrPred_f;
  logic              BrPred_x;
  logic [CWIDTH-1:0] br_count;
  logic [CWIDTH-1:0] mispred_count;

  modport master (
    output pc_f, Br_f, Br_x, BrTrue, stall, flush,
    input  BrPred_f, BrPred_x, br_count, mispred_count
  );

  modport slave (
    input  pc_f, Br_f, Br_x, BrTrue, stall, flush,
    output BrPred_f, BrPred_x, br_count, mispred_count
  );
endinterface

// File: rtl/bp_counter_table.sv
// Table of 2-bit saturating counters: one combinational read, one clocked write.
module bp_counter_table
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W      = IDX_W_DEFAULT,
  parameter logic [1:0]  INIT_STATE = WNT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_state,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);
  localparam int unsigned Entries = 2 ** IDX_W;

  logic [1:0] ctr_q [Entries];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Entries; i++) begin
        ctr_q[i] <= INIT_STATE;
      end
    end else if (wr_en) begin
      ctr_q[wr_idx] <= sat_update(ctr_q[wr_idx], wr_taken);
    end
  end

  // No bypass: a same-cycle write to rd_idx is seen on the next cycle.
  assign rd_state = ctr_q[rd_idx];

endmodule

// File: rtl/branch_predictor_bht.sv
// PC-indexed bimodal branch predictor with F->X prediction pipe and perf counters.
module branch_predictor_bht
  import bp_pkg::*;
#(
  parameter int unsigned AWIDTH     = 32,
  parameter int unsigned IDX_W      = IDX_W_DEFAULT,
  parameter logic [1:0]  INIT_STATE = WNT,
  parameter int unsigned CWIDTH     = 32
) (
  input logic                   clk,
  input logic                   rst_n,
  branch_predictor_bht_if.slave bus
);
  logic [IDX_W-1:0]  idx_f;
  logic [IDX_W-1:0]  idx_x_q;
  logic [1:0]        rd_state;
  logic              pred_f;
  logic              pred_x_q;
  logic              res;
  logic [CWIDTH-1:0] br_count_q;
  logic [CWIDTH-1:0] mispred_count_q;
  logic              unused_pc;

  assign idx_f     = bus.pc_f[IDX_W+1:2];
  assign unused_pc = ^{bus.pc_f[AWIDTH-1:IDX_W+2], bus.pc_f[1:0]};
  assign pred_f    = bus.Br_f & rd_state[1];

  // Operands of a stalled branch are not valid yet, so it neither trains nor counts.
  assign res = bus.Br_x & ~bus.stall;

  bp_counter_table #(
    .IDX_W      (IDX_W),
    .INIT_STATE (INIT_STATE)
  ) u_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (idx_f),
    .rd_state (rd_state),
    .wr_en    (res),
    .wr_idx   (idx_x_q),
    .wr_taken (bus.BrTrue)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_x_q        <= 1'b0;
      idx_x_q         <= '0;
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      if (!bus.stall) begin
        if (bus.flush) begin
          pred_x_q <= 1'b0;
        end else begin
          pred_x_q <= pred_f;
          idx_x_q  <= idx_f;
        end
      end
      // Flush does not gate this: the redirecting branch itself still counts.
      if (res) begin
        br_count_q <= br_count_q + CWIDTH'(1);
        if (bus.BrTrue != pred_x_q) begin
          mispred_count_q <= mispred_count_q + CWIDTH'(1);
        end
      end
    end
  end

  assign bus.BrPred_f      = pred_f;
  assign bus.BrPred_x      = pred_x_q;
  assign bus.br_count      = br_count_q;
  assign bus.mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench for branch_predictor_bht with a reference model and scoreboard queue.
module tb_branch_predictor_bht;

  typedef struct packed {
    logic       px;
    logic [3:0] br;
    logic [3:0] mis;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  logic [1:0] m_tbl [64];
  logic       m_px;
  logic [5:0] m_ix;
  logic [3:0] m_br;
  logic [3:0] m_mis;
  exp_t       sb [$];

  branch_predictor_bht_if #(.AWIDTH(32), .CWIDTH(4)) bus ();

  branch_predictor_bht #(
    .AWIDTH     (32),
    .IDX_W      (6),
    .INIT_STATE (2'b01),
    .CWIDTH     (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_tbl[i] = 2'b01;
    m_px  = 1'b0;
    m_ix  = '0;
    m_br  = '0;
    m_mis = '0;
  endtask

  // Combinational lookup only; never spans a clock edge.
  task automatic peek(input string tag, input logic [31:0] pc, input logic exp);
    bus.pc_f   = pc;
    bus.Br_f   = 1'b1;
    bus.Br_x   = 1'b0;
    bus.stall  = 1'b0;
    bus.flush  = 1'b0;
    #1;
    chk(tag, {31'd0, bus.BrPred_f}, {31'd0, exp});
  endtask

  task automatic step(input logic [31:0] pc, input logic bf, input logic bx, input logic tk,
                      input logic st, input logic fl);
    logic [5:0] idx;
    logic       ef;
    exp_t       e;
    bus.pc_f   = pc;
    bus.Br_f   = bf;
    bus.Br_x   = bx;
    bus.BrTrue = tk;
    bus.stall  = st;
    bus.flush  = fl;
    #2;
    idx = pc[7:2];
    ef  = bf & m_tbl[idx][1];
    chk("pred_f", {31'd0, bus.BrPred_f}, {31'd0, ef});
    if (bx && !st) begin
      m_br = m_br + 4'd1;
      if (tk != m_px) m_mis = m_mis + 4'd1;
      if (tk) m_tbl[m_ix] = (m_tbl[m_ix] == 2'b11) ? 2'b11 : m_tbl[m_ix] + 2'd1;
      else    m_tbl[m_ix] = (m_tbl[m_ix] == 2'b00) ? 2'b00 : m_tbl[m_ix] - 2'd1;
    end
    if (!st) begin
      if (fl) begin
        m_px = 1'b0;
      end else begin
        m_px = ef;
        m_ix = idx;
      end
    end
    e.px  = m_px;
    e.br  = m_br;
    e.mis = m_mis;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("pred_x", {31'd0, bus.BrPred_x}, {31'd0, e.px});
    chk("br_count", {28'd0, bus.br_count}, {28'd0, e.br});
    chk("mispred_count", {28'd0, bus.mispred_count}, {28'd0, e.mis});
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    bus.pc_f   = '0;
    bus.Br_f   = 1'b0;
    bus.Br_x   = 1'b0;
    bus.BrTrue = 1'b0;
    bus.stall  = 1'b0;
    bus.flush  = 1'b0;
    model_reset();

    // Reset state
    #3;
    chk("rst_pred_x", {31'd0, bus.BrPred_x}, 32'd0);
    chk("rst_br_count", {28'd0, bus.br_count}, 32'd0);
    chk("rst_mispred", {28'd0, bus.mispred_count}, 32'd0);
    peek("rst_lookup_100", 32'h100, 1'b0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    step(32'h100, 1, 0, 0, 0, 0);
    chk("first_pred_x", {31'd0, bus.BrPred_x}, 32'd0);

    // Train taken to saturation at idx 0
    step(32'h0,   0, 1, 1, 0, 0);
    step(32'h100, 1, 0, 0, 0, 0);
    chk("trained_pred_x", {31'd0, bus.BrPred_x}, 32'd1);
    step(32'h0,   0, 1, 1, 0, 0);
    step(32'h100, 1, 0, 0, 0, 0);
    step(32'h0,   0, 1, 1, 0, 0);
    chk("train_br3", {28'd0, bus.br_count}, 32'd3);
    chk("train_mis1", {28'd0, bus.mispred_count}, 32'd1);
    peek("sat_lookup", 32'h100, 1'b1);

    // Mispredict resolved together with a flush
    step(32'h100, 1, 0, 0, 0, 0);
    step(32'h100, 1, 1, 0, 0, 1);
    chk("flush_pred_x", {31'd0, bus.BrPred_x}, 32'd0);
    chk("flush_mis2", {28'd0, bus.mispred_count}, 32'd2);

    // Stall holds pred_x and suppresses training/counting
    step(32'h100, 1, 0, 0, 0, 0);
    step(32'h0,   0, 1, 1, 1, 0);
    step(32'h0,   0, 1, 1, 1, 0);
    chk("stall_pred_x", {31'd0, bus.BrPred_x}, 32'd1);
    chk("stall_br4", {28'd0, bus.br_count}, 32'd4);
    step(32'h0,   0, 1, 1, 0, 0);
    chk("release_br5", {28'd0, bus.br_count}, 32'd5);

    // Same-index lookup and update on idx 5
    step(32'h14,  1, 0, 0, 0, 0);
    step(32'h14,  1, 1, 1, 0, 0);
    peek("collide_next", 32'h14, 1'b1);

    // Aliasing: 0x000 and 0x100 share idx 0
    peek("alias_pre", 32'h0, 1'b1);
    step(32'h0,   1, 0, 0, 0, 0);
    step(32'h0,   0, 1, 0, 0, 0);
    step(32'h0,   1, 0, 0, 0, 0);
    step(32'h0,   0, 1, 0, 0, 0);
    peek("alias_post", 32'h100, 1'b0);

    // Counter wrap (4-bit counters in this bench)
    for (int i = 0; i < 16 && m_br != 4'd15; i++) begin
      step(32'h40, 0, 1, 0, 0, 0);
    end
    chk("pre_wrap_br", {28'd0, bus.br_count}, 32'd15);
    step(32'h40, 0, 1, 0, 0, 0);
    chk("wrap_br0", {28'd0, bus.br_count}, 32'd0);

    // Asynchronous reset mid-cycle
    peek("pre_reset_idx5", 32'h14, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_pred_x", {31'd0, bus.BrPred_x}, 32'd0);
    chk("async_br", {28'd0, bus.br_count}, 32'd0);
    chk("async_mis", {28'd0, bus.mispred_count}, 32'd0);
    peek("async_idx5", 32'h14, 1'b0);
    model_reset();
    rst_n = 1'b1;
    step(32'h14, 1, 0, 0, 0, 0);
    step(32'h0,  0, 1, 1, 0, 0);
    chk("post_reset_br1", {28'd0, bus.br_count}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
